// File: rtl/dbg_inst_encoder.sv
// dbg_inst_encoder: turns debug read/write commands into LUI/ADDI/SW/LW sequences for instruction injection
module dbg_inst_encoder #(
  parameter logic [4:0] RA_REG = 5'd1,
  parameter logic [4:0] RD_REG = 5'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        cmd_done
);
  typedef enum logic [2:0] {IDLE, A_HI, A_LO, D_HI, D_LO, MEM} state_e;

  if (RA_REG == 5'd0 || RD_REG == 5'd0 || RA_REG == RD_REG) begin : g_bad_regs
    $error("dbg_inst_encoder: RA_REG/RD_REG must be nonzero and distinct");
  end

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d, done_q, done_d;

  function automatic state_e next_state(input state_e s, input logic op);
    return s == A_HI ? A_LO :
           s == A_LO ? (op ? MEM : D_HI) :
           s == D_HI ? D_LO :
           s == D_LO ? MEM : IDLE;
  endfunction

  // The +0x800 bias in the upper part compensates for ADDI sign-extending the low 12 bits.
  function automatic logic [31:0] encode(input state_e s, input logic op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    logic [31:0] hi;
    logic [4:0]  r;
    v  = (s == D_HI || s == D_LO) ? d : a;
    r  = (s == D_HI || s == D_LO) ? RD_REG : RA_REG;
    hi = v + 32'h800;
    return (s == A_HI || s == D_HI) ? {hi[31:12], r, 7'b0110111} :
           (s == A_LO || s == D_LO) ? {v[11:0], r, 3'b000, r, 7'b0010011} :
           (s == MEM && op)         ? {12'b0, RA_REG, 3'b010, RD_REG, 7'b0000011} :
           (s == MEM)               ? {7'b0, RD_REG, RA_REG, 3'b010, 5'b0, 7'b0100011} :
                                      32'h0;
  endfunction

  // Accept in IDLE, advance on handshake; inst register always holds the encoding of the next state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (state_q == IDLE && cmd_valid) begin
      state_d = A_HI;
      op_d    = cmd_op;
      addr_d  = cmd_addr;
      data_d  = cmd_data;
    end else if (state_q != IDLE && inst_ready) begin
      state_d = next_state(state_q, op_q);
    end
    inst_d       = encode(state_d, op_d, addr_d, data_d);
    inst_valid_d = state_d != IDLE;
    done_d       = state_q == MEM && inst_ready;
  end

  // State and output registers with asynchronous abort on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= 1'b0;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      done_q       <= done_d;
    end
  end

  assign cmd_ready  = state_q == IDLE && !rst;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign cmd_done   = done_q;
endmodule

// File: tb/tb_dbg_inst_encoder.sv
// tb_dbg_inst_encoder: vector table, hand sequences and randomized model checks for dbg_inst_encoder
module tb_dbg_inst_encoder;
  typedef logic [0:4][31:0] seq_t;
  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] data;
    int          mode;
    seq_t        w;
    int          n;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_op = 1'b0, inst_ready = 1'b0;
  logic [31:0] cmd_addr = 32'h0, cmd_data = 32'h0;
  logic        cmd_ready, inst_valid, cmd_done;
  logic [31:0] inst;
  int          n_cmp = 0, n_fail = 0;

  dbg_inst_encoder dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .cmd_done(cmd_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [31:0] v);
    logic [31:0] t;
    t = v + 32'h800;
    return {t[31:12], rd, 7'h37};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [31:0] v);
    return {v[11:0], rd, 3'b000, rd, 7'h13};
  endfunction

  function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] d,
                                output seq_t w, output int n);
    w = '0;
    w[0] = lui(5'd1, a);
    w[1] = addi(5'd1, a);
    if (op) begin
      w[2] = {12'b0, 5'd1, 3'b010, 5'd2, 7'h03};
      n = 3;
    end else begin
      w[2] = lui(5'd2, d);
      w[3] = addi(5'd2, d);
      w[4] = {7'b0, 5'd2, 5'd1, 3'b010, 5'b0, 7'h23};
      n = 5;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always, 1: three stall cycles per word, 2: random ready
  task automatic collect(input seq_t w, input int n, input int mode);
    int i = 0, cyc = 0, sc = 0;
    while (i < n && cyc < 100) begin
      check("inst_valid", {31'b0, inst_valid}, 32'h1);
      check("inst", inst, w[i]);
      check("busy_ready", {31'b0, cmd_ready}, 32'h0);
      check("busy_done", {31'b0, cmd_done}, 32'h0);
      inst_ready = mode == 0 ? 1'b1 : mode == 1 ? (sc == 3) : 1'($urandom_range(0, 1));
      tick();
      if (inst_ready) begin
        i++;
        sc = 0;
      end else sc++;
      cyc++;
    end
    if (cyc >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got %0d words expected %0d", i, n);
    end
    check("done_pulse", {31'b0, cmd_done}, 32'h1);
    check("done_valid", {31'b0, inst_valid}, 32'h0);
    check("done_ready", {31'b0, cmd_ready}, 32'h1);
    inst_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic op, input logic [31:0] a, input logic [31:0] d,
                         input seq_t w, input int n, input int mode);
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    cmd_valid = 1'b1;
    check("accept_ready", {31'b0, cmd_ready}, 32'h1);
    tick();
    cmd_valid = 1'b0;
    collect(w, n, mode);
  endtask

  vec_t vecs[4];
  seq_t ws, wb;
  int   n, nb;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1000, 32'h1234_5678, 0,
                {32'h000010B7, 32'h00008093, 32'h12345137, 32'h67810113, 32'h0020A023}, 5};
    vecs[1] = '{1'b0, 32'h0000_1000, 32'h0000_0800, 0,
                {32'h000010B7, 32'h00008093, 32'h00001137, 32'h80010113, 32'h0020A023}, 5};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 0,
                {32'h000000B7, 32'hFFC08093, 32'h0000A103, 32'h0, 32'h0}, 3};
    vecs[3] = '{1'b0, 32'h0000_1000, 32'h1234_5678, 1,
                {32'h000010B7, 32'h00008093, 32'h12345137, 32'h67810113, 32'h0020A023}, 5};

    cmd_valid = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    check("rst_ready", {31'b0, cmd_ready}, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_done", {31'b0, cmd_done}, 32'h0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, cmd_ready}, 32'h1);
    tick();
    check("idle_valid", {31'b0, inst_valid}, 32'h0);
    inst_ready = 1'b0;

    for (int k = 0; k < 4; k++) begin
      run_cmd(vecs[k].op, vecs[k].addr, vecs[k].data, vecs[k].w, vecs[k].n, vecs[k].mode);
      tick();
      check("gap_done", {31'b0, cmd_done}, 32'h0);
    end

    cmd_op = 1'b0;
    cmd_addr = 32'h0000_1000;
    cmd_data = 32'h1234_5678;
    cmd_valid = 1'b1;
    inst_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t5_ahi", inst, 32'h000010B7);
    tick();
    check("t5_alo", inst, 32'h00008093);
    tick();
    check("t5_dhi", inst, 32'h12345137);
    #2 rst = 1'b1;
    #1;
    check("t5_valid", {31'b0, inst_valid}, 32'h0);
    check("t5_inst", inst, 32'h0);
    check("t5_ready", {31'b0, cmd_ready}, 32'h0);
    check("t5_done", {31'b0, cmd_done}, 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_no_done", {31'b0, cmd_done}, 32'h0);
      check("t5_idle", {31'b0, inst_valid}, 32'h0);
    end
    inst_ready = 1'b0;
    run_cmd(vecs[2].op, vecs[2].addr, vecs[2].data, vecs[2].w, vecs[2].n, 0);

    model(1'b1, 32'h0000_2468, 32'h0, ws, n);
    model(1'b0, 32'h8000_0FFF, 32'hCAFE_F800, wb, nb);
    cmd_op = 1'b1;
    cmd_addr = 32'h0000_2468;
    cmd_data = 32'h0;
    cmd_valid = 1'b1;
    tick();
    cmd_op = 1'b0;
    cmd_addr = 32'h8000_0FFF;
    cmd_data = 32'hCAFE_F800;
    collect(ws, n, 0);
    tick();
    cmd_valid = 1'b0;
    collect(wb, nb, 0);

    for (int k = 0; k < 30; k++) begin
      logic        op;
      logic [31:0] a, d;
      op = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      if (k % 3 == 0) a[11:0] = 12'h7FF + 12'($urandom_range(0, 2));
      if (k % 4 == 0) d[11:0] = 12'h800;
      model(op, a, d, ws, n);
      run_cmd(op, a, d, ws, n, 2);
      if ($urandom_range(0, 1) == 1) begin
        inst_ready = 1'($urandom_range(0, 1));
        tick();
        check("rand_gap_valid", {31'b0, inst_valid}, 32'h0);
        check("rand_gap_done", {31'b0, cmd_done}, 32'h0);
        inst_ready = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
